// File: rtl/uart_tx_sched.sv
// Round-robin arbiter sharing one UART TX line among N_REQ requesters.
// Each frame: grant, realign the baud generator for one cycle, then send 8N1/8N2 on bd pulses.
module uart_tx_sched #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned STOP_BITS  = 1,
  parameter logic [31:0] BD_TIMEOUT = 32'd65535
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [8*N_REQ-1:0]   i_data,
  input  logic [2*N_REQ-1:0]   i_rate,
  input  logic                 i_bd,
  output logic [1:0]           o_bd_rate,
  output logic                 o_bg_n_rst,
  output logic [N_REQ-1:0]     o_grant,
  output logic [N_REQ-1:0]     o_ack,
  output logic                 o_done,
  output logic                 o_err,
  output logic                 o_busy,
  output logic                 o_tx
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {StIdle, StSync, StStart, StData, StStop} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [IdxW-1:0]  r_last;
  logic [IdxW-1:0]  w_win;
  logic [IdxW:0]    w_j;
  logic             w_found;
  logic [N_REQ-1:0] w_onehot;
  logic [N_REQ-1:0] r_grant;
  logic [7:0]       r_shift;
  logic [2:0]       r_idx;
  logic [1:0]       r_stop_cnt;
  logic [31:0]      r_tmo;
  logic [1:0]       r_rate;
  logic             w_tmo_hit;

  // Scan from the requester after the last winner, wrapping, so every requester gets a turn.
  always_comb begin
    w_found  = 1'b0;
    w_win    = r_last;
    w_j      = '0;
    w_onehot = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_j = {1'b0, r_last} + (IdxW + 1)'(k);
      if (w_j >= (IdxW + 1)'(N_REQ)) begin
        w_j = w_j - (IdxW + 1)'(N_REQ);
      end
      if (!w_found && i_req[w_j[IdxW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_j[IdxW-1:0];
      end
    end
    w_onehot[w_win] = 1'b1;
  end

  // A bd landing on the threshold cycle wins over the abort.
  assign w_tmo_hit = (r_tmo == BD_TIMEOUT - 32'd1) && !i_bd;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_ack        = '0;
    o_done       = 1'b0;
    o_err        = 1'b0;
    o_tx         = 1'b1;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          o_ack        = w_onehot;
          w_state_next = StSync;
        end
      end
      StSync: w_state_next = StStart;
      StStart: begin
        o_tx = 1'b0;
        if (w_tmo_hit) begin
          o_err        = 1'b1;
          w_state_next = StIdle;
        end else if (i_bd) begin
          w_state_next = StData;
        end
      end
      StData: begin
        o_tx = r_shift[0];
        if (w_tmo_hit) begin
          o_err        = 1'b1;
          w_state_next = StIdle;
        end else if (i_bd && r_idx == 3'd7) begin
          w_state_next = StStop;
        end
      end
      StStop: begin
        if (w_tmo_hit) begin
          o_err        = 1'b1;
          w_state_next = StIdle;
        end else if (i_bd && r_stop_cnt == 2'(STOP_BITS - 1)) begin
          o_done       = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
    if (i_rst) begin
      o_ack  = '0;
      o_done = 1'b0;
      o_err  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant    <= '0;
      r_last     <= IdxW'(N_REQ - 1);
      r_shift    <= '0;
      r_idx      <= '0;
      r_stop_cnt <= '0;
      r_tmo      <= '0;
      r_rate     <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_grant <= w_onehot;
            r_last  <= w_win;
            r_shift <= i_data[{w_win, 3'b000} +: 8];
            r_rate  <= i_rate[{w_win, 1'b0} +: 2];
          end
        end
        StSync: begin
          r_tmo      <= '0;
          r_idx      <= '0;
          r_stop_cnt <= '0;
        end
        StStart, StData, StStop: begin
          r_tmo <= i_bd ? 32'd0 : r_tmo + 32'd1;
          if (i_bd && r_state == StData) begin
            r_shift <= {1'b0, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
          end
          if (i_bd && r_state == StStop) begin
            r_stop_cnt <= r_stop_cnt + 2'd1;
          end
          if (w_state_next == StIdle) begin
            r_grant <= '0;
            r_tmo   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_grant    = r_grant;
  assign o_bd_rate  = r_rate;
  assign o_bg_n_rst = (r_state != StSync);
  assign o_busy     = (r_state != StIdle);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized self-checking bench for uart_tx_sched with a frame-level reference model.
// A small baud generator model restarts on bg_n_rst and pulses bd every `period` clocks.
module tb_uart_tx_sched;

  localparam logic [31:0] TMO = 32'd100;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req2;
  logic [31:0] data, data2;
  logic [7:0]  rate, rate2;
  logic        bd, bd2, bd_en;
  int          period = 7;
  int          cnt = 0, cnt2 = 0;

  logic [1:0]  bd_rate, bd_rate2;
  logic        bg_n_rst, bg_n_rst2;
  logic [3:0]  grant, grant2, ack, ack2;
  logic        done, done2, err, err2, busy, busy2, tx, tx2;

  int passed = 0;
  int total  = 0;
  int m_last;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!bg_n_rst || cnt >= period - 1) cnt <= 0;
    else cnt <= cnt + 1;
  end
  assign bd = bd_en && (cnt == period - 1);

  always @(posedge clk) begin
    if (!bg_n_rst2 || cnt2 >= 9) cnt2 <= 0;
    else cnt2 <= cnt2 + 1;
  end
  assign bd2 = (cnt2 == 9);

  uart_tx_sched #(.N_REQ(4), .STOP_BITS(1), .BD_TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data), .i_rate(rate), .i_bd(bd),
    .o_bd_rate(bd_rate), .o_bg_n_rst(bg_n_rst), .o_grant(grant), .o_ack(ack),
    .o_done(done), .o_err(err), .o_busy(busy), .o_tx(tx)
  );

  uart_tx_sched #(.N_REQ(4), .STOP_BITS(2), .BD_TIMEOUT(32'd65535)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_req(req2), .i_data(data2), .i_rate(rate2), .i_bd(bd2),
    .o_bd_rate(bd_rate2), .o_bg_n_rst(bg_n_rst2), .o_grant(grant2), .o_ack(ack2),
    .o_done(done2), .o_err(err2), .o_busy(busy2), .o_tx(tx2)
  );

  // Round-robin rule: first set request after `last`, wrapping modulo 4.
  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle (1 time unit after the edge); ends in the IDLE cycle after done.
  task automatic do_frame(input logic [3:0] req_v, input logic [31:0] data_v,
                          input logic [7:0] rate_v, input int per,
                          input logic [31:0] data_after, input logic [3:0] req_after,
                          input string tag);
    int w;
    logic [7:0]  b;
    logic [1:0]  r;
    logic [3:0]  oh;
    logic [10:0] f;
    logic [13:0] got, want;
    w  = pick(req_v, m_last);
    b  = data_v[8*w +: 8];
    r  = rate_v[2*w +: 2];
    oh = 4'b0001 << w;
    f  = {2'b11, b, 1'b0};
    period = per;
    req  = req_v;
    data = data_v;
    rate = rate_v;
    #1;
    total++;
    if (ack !== oh) $display("FAIL %s ack got %b want %b", tag, ack, oh);
    else passed++;
    m_last = w;
    tick();
    got  = {ack, done, err, grant, bd_rate, bg_n_rst, busy, tx};
    want = {4'b0000, 1'b0, 1'b0, oh, r, 1'b0, 1'b1, 1'b1};
    total++;
    if (got !== want) $display("FAIL %s sync got %b want %b", tag, got, want);
    else passed++;
    req  = req_after;
    data = data_after;
    rate = ~rate_v;
    tick();
    for (int i = 0; i < 11; i++) begin
      for (int c = 0; c < per; c++) begin
        total++;
        if (tx !== f[i]) $display("FAIL %s tx bit %0d cyc %0d got %b want %b",
                                  tag, i, c, tx, f[i]);
        else passed++;
        got  = {ack, done, err, grant, bd_rate, bg_n_rst, busy, 1'b0};
        want = {4'b0000, (i == 9 && c == per - 1), 1'b0, oh, r, 1'b1, 1'b1, 1'b0};
        total++;
        if (got !== want) $display("FAIL %s ctl bit %0d cyc %0d got %b want %b",
                                   tag, i, c, got, want);
        else passed++;
        if (i == 9 && c == per - 1) break;
        tick();
      end
      if (i == 9) break;
    end
    tick();
    got  = {grant, busy, tx, bg_n_rst, done, err, 4'b0000};
    want = {4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000};
    total++;
    if (got !== want) $display("FAIL %s idle got %b want %b", tag, got, want);
    else passed++;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 4'b1111; req2 = 4'b0000; bd_en = 1'b1;
    data = '0; rate = '0; data2 = '0; rate2 = '0;
    repeat (3) tick();
    total++;
    if ({tx, grant, ack, done, err, busy, bd_rate, bg_n_rst} !== 15'b1_0000_0000_0_0_0_00_1)
      $display("FAIL reset outs got %b want %b",
               {tx, grant, ack, done, err, busy, bd_rate, bg_n_rst}, 15'b1_0000_0000_0_0_0_00_1);
    else passed++;
    total++;
    if ({tx2, grant2, busy2, bg_n_rst2} !== 7'b1_0000_0_1)
      $display("FAIL reset dut2 got %b want %b", {tx2, grant2, busy2, bg_n_rst2}, 7'b1000001);
    else passed++;
    rst = 1'b0; req = 4'b0000;
    m_last = 3;
    tick();
    total++;
    if ({busy, grant, ack} !== 9'b0) $display("FAIL reset idle got %b want %b",
                                             {busy, grant, ack}, 9'b0);
    else passed++;
  endtask

  task automatic test_round_robin;
    for (int n = 0; n < 5; n++) begin
      do_frame(4'b1111, $urandom, 8'($urandom), 4 + n, $urandom, 4'b1111, "rr");
    end
  endtask

  task automatic test_single;
    do_frame(4'b0100, 32'h00A5_0000, 8'b0001_0000, 20, $urandom, 4'b0000, "single");
  endtask

  task automatic test_stability;
    do_frame(4'b0001, 32'h0000_003C, 8'($urandom), 6, 32'h0000_00FF, 4'b0000, "stable");
  endtask

  task automatic test_fairness;
    period = 6;
    req  = 4'b0100;
    data = $urandom;
    rate = 8'($urandom);
    tick();
    req = 4'b0000;
    repeat (1 + period + 3) tick();
    total++;
    if (busy !== 1'b1) $display("FAIL fair busy before rst got %b want 1", busy);
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_last = 3;
    total++;
    if ({tx, grant, busy, ack, bd_rate, bg_n_rst} !== 13'b1_0000_0_0000_00_1)
      $display("FAIL fair after rst got %b want %b",
               {tx, grant, busy, ack, bd_rate, bg_n_rst}, 13'b1_0000_0_0000_00_1);
    else passed++;
    do_frame(4'b0101, $urandom, 8'($urandom), 5, $urandom, 4'b0101, "fair0");
    do_frame(4'b0101, $urandom, 8'($urandom), 5, $urandom, 4'b0000, "fair2");
  endtask

  task automatic test_timeout;
    logic [7:0] b;
    period = 8;
    req  = 4'b0010;
    data = $urandom;
    rate = 8'($urandom);
    b    = data[15:8];
    #1;
    total++;
    if (ack !== 4'b0010) $display("FAIL tmo ack got %b want 0010", ack);
    else passed++;
    m_last = 1;
    tick();
    req = 4'b0000;
    tick();
    repeat (period) tick();
    bd_en = 1'b0;
    for (int k = 1; k <= int'(TMO); k++) begin
      total++;
      if ({err, done, tx, grant} !== {(k == int'(TMO)), 1'b0, b[0], 4'b0010})
        $display("FAIL tmo k=%0d got %b want %b", k, {err, done, tx, grant},
                 {(k == int'(TMO)), 1'b0, b[0], 4'b0010});
      else passed++;
      tick();
    end
    total++;
    if ({tx, grant, busy, err, done} !== 8'b1_0000_0_0_0)
      $display("FAIL tmo after got %b want %b", {tx, grant, busy, err, done}, 8'b10000000);
    else passed++;
    bd_en = 1'b1;
    do_frame(4'b0110, $urandom, 8'($urandom), 5, $urandom, 4'b0000, "tmo_next");
  endtask

  task automatic test_boundary;
    do_frame(4'($urandom_range(1, 15)), $urandom, 8'($urandom), int'(TMO), $urandom,
             4'b0000, "bd_at_tmo");
  endtask

  task automatic test_random;
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        req = 4'b0000;
        for (int g = 0; g < 3; g++) begin
          total++;
          if ({ack, busy, grant} !== 9'b0) $display("FAIL gap got %b want 0", {ack, busy, grant});
          else passed++;
          tick();
        end
      end
      do_frame(4'($urandom_range(1, 15)), $urandom, 8'($urandom), $urandom_range(3, 9),
               $urandom, 4'($urandom_range(0, 15)), "rand");
    end
    req = 4'b0000;
  endtask

  task automatic test_stop2;
    int w;
    logic [3:0]  rv, oh;
    logic [7:0]  b;
    logic [11:0] f;
    rv = 4'($urandom_range(1, 15));
    w  = pick(rv, 3);
    oh = 4'b0001 << w;
    data2 = $urandom;
    rate2 = 8'($urandom);
    b  = data2[8*w +: 8];
    f  = {3'b111, b, 1'b0};
    req2 = rv;
    #1;
    total++;
    if (ack2 !== oh) $display("FAIL stop2 ack got %b want %b", ack2, oh);
    else passed++;
    tick();
    total++;
    if ({bg_n_rst2, grant2} !== {1'b0, oh})
      $display("FAIL stop2 sync got %b want %b", {bg_n_rst2, grant2}, {1'b0, oh});
    else passed++;
    req2  = 4'b0000;
    data2 = ~data2;
    tick();
    for (int i = 0; i < 11; i++) begin
      for (int c = 0; c < 10; c++) begin
        total++;
        if ({tx2, done2, err2, grant2} !== {f[i], (i == 10 && c == 9), 1'b0, oh})
          $display("FAIL stop2 bit %0d cyc %0d got %b want %b", i, c,
                   {tx2, done2, err2, grant2}, {f[i], (i == 10 && c == 9), 1'b0, oh});
        else passed++;
        tick();
      end
    end
    total++;
    if ({grant2, busy2, tx2, done2} !== 7'b0000_0_1_0)
      $display("FAIL stop2 idle got %b want %b", {grant2, busy2, tx2, done2}, 7'b0000010);
    else passed++;
  endtask

  initial begin
    #1;
    test_reset();
    test_round_robin();
    test_single();
    test_stability();
    test_fairness();
    test_timeout();
    test_boundary();
    test_random();
    test_stop2();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmit line among N_REQ requesters.
- Each requester supplies a byte and a 2-bit baud-rate select.
- Per frame, the block grants one requester and drives bd_rate to the baud generator. It realigns the generator by holding it in reset for one cycle, then serializes an 8N1/8N2 frame by stepping on the generator's bd bit pulse.
- Sits between the soda-machine command/report logic and the baud generator/TX pin.

Parameters:
N_REQ, 4, number of requesters (2..8)
STOP_BITS, 1, stop bits per frame (1 or 2)
BD_TIMEOUT, 32'd65535, max clk cycles allowed between bd pulses in a bit state before abort

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req  input  N_REQ  per-requester transmit request, level
data  input  8*N_REQ  byte for requester i at [8i+7:8i]
rate  input  2*N_REQ  baud select for requester i at [2i+1:2i] (00=9600, 01=19200, 10=57600, 11=115200)
bd  input  1  one-clk bit-period pulse from baud generator
bd_rate  output  2  baud select driven to baud generator
bg_n_rst  output  1  active-low realign pulse to baud generator
grant  output  N_REQ  one-hot owner of current frame, 0 when idle
ack  output  N_REQ  one-clk pulse: byte of requester i latched
done  output  1  one-clk pulse: frame completed normally
err  output  1  one-clk pulse: frame aborted on bd timeout
busy  output  1  high in any state other than IDLE
tx  output  1  serial line, idle high

Behaviour:
- Reset (rst=1 at clk edge, also mid-frame):
  - state=IDLE, tx=1, grant=0, ack=0, done=0, err=0, busy=0, bd_rate=2'b00, bg_n_rst=1.
  - Round-robin pointer last=N_REQ-1, so requester 0 has first priority.
  - Timeout counter, bit index and shift register cleared.
- States: IDLE, SYNC, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If req!=0: pick the first set req scanning from index last+1 upward, wrapping modulo N_REQ.
  - Latch data and rate of winner; set grant one-hot; pulse ack[winner] that cycle; bd_rate<=latched rate; last<=winner; go to SYNC.
  - No req: stay.
- SYNC:
  - Exactly one cycle.
  - bg_n_rst=0 this cycle only; tx=1.
  - Next state START.
- START:
  - tx=0; on bd go to DATA with bit index 0.
- DATA:
  - tx=shift[0], LSB first.
  - On bd: shift right, index+1. On bd with index==7, go to STOP with stop count 0.
- STOP:
  - tx=1; on bd, stop count+1.
  - When count reaches STOP_BITS: pulse done, grant<=0, go to IDLE.
- Latency: ack at cycle T, bg_n_rst low at T+1, tx falls at T+2.
- Frame length: start bit ends on the first bd after SYNC. Frame = 10 (or 11) bd periods.
- Back-to-back: the next arbitration happens in the IDLE cycle after done, giving a minimum 1 clk of idle-high between frames.
- bd in IDLE or SYNC is ignored.
- Timeout:
  - In START/DATA/STOP a 32-bit counter clears on entry and on each bd, and increments otherwise.
  - Reaching BD_TIMEOUT: tx<=1, grant<=0, err pulse, no done, go to IDLE; last still updated.
- Input changes while granted:
  - Changes on req, data or rate are ignored; only values at the grant cycle matter.
  - Deasserting req mid-frame does not abort.
  - bd_rate holds its latched value until the next grant, including through IDLE.
- Simultaneous events:
  - bd coincident with the timeout threshold counts as bd; no abort.
  - rst overrides everything.
- done, err and ack are never high in the same cycle.

Test Plan:
- Single frame: N_REQ=4, STOP_BITS=1. req=4'b0100, data[23:16]=8'hA5, rate[5:4]=2'b01, bd pulse every 20 clk.
  - ack=4'b0100 and grant=4'b0100.
  - bd_rate=01; bg_n_rst low one cycle.
  - tx sequence is 0,1,0,1,0,0,1,0,1,1 with each bit lasting one bd period, LSB first.
  - done pulses once; grant returns to 0.
- Round-robin: req=4'b1111 held, four frames in a row. Grant order is 0,1,2,3, then 0; each ack pulses once per frame.
- Fairness after reset: rst mid-DATA of requester 2's frame.
  - Next cycle tx=1, grant=0, busy=0.
  - With req=4'b0101, requester 0 is granted first, then 2.
- Timeout: grant requester 1 with BD_TIMEOUT=100 and stop bd after the start bit.
  - err pulses 100 clk after the last bd; tx=1; done never pulses.
  - Next grant goes to requester 2 when req=4'b0110.
- Input stability: change data[7:0] from 8'h3C to 8'hFF and drop req[0] one cycle after ack[0]. The serialized byte is still 8'h3C and done pulses.
- STOP_BITS=2 with bd every 10 clk: the frame spans 11 bd periods with the last two bits high, and done pulses on the 11th bd.
